banco_reg_wb: RTL and testbench

- Write-back register bank of the multicycle MIPS datapath.
- Sits directly downstream of the register-destination selector and consumes its output as the write address.
- Holds the 32×32-bit architectural registers and provides two combinational read ports.
- Also latches the operand registers A and B that feed the ALU stage, with write-to-read bypass so A/B never capture stale data.

---
 rtl/banco_reg_wb_pkg.sv | 17 +
 rtl/banco_reg_wb_operand_latch.sv | 50 +++++
 rtl/banco_reg_wb.sv | 124 ++++++++++++
 tb/tb_banco_reg_wb.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/banco_reg_wb_pkg.sv
// Shared constants for the write-back register bank and the destination selector.
package banco_reg_wb_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int REG_ZERO     = 0;
    localparam int REG_SP       = 29;
    localparam int REG_RA       = 31;
    localparam int SP_RESET_VAL = 227;
    localparam int TRACE_CNT_W  = 16;

    // A write only reaches the bank when enabled and not aimed at the hard-wired zero register.
    function automatic logic wr_accepted(input logic we, input logic [ADDR_W-1:0] addr);
        return we && (addr != ADDR_W'(REG_ZERO));
    endfunction

endpackage

// File: rtl/banco_reg_wb_operand_latch.sv
// Operand latch (A or B): write-first bypass select in front of an enable register.
module banco_reg_wb_operand_latch
    import banco_reg_wb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] bypass_s;
    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] val_q;

    // Select in-flight write data when it targets the register being read, so the latch never captures stale data.
    always_comb begin
        bypass_s = rd_data;
        val_d    = val_q;
        if (wr_en && (wr_addr == rd_addr) && (wr_addr != AW'(REG_ZERO))) begin
            bypass_s = wr_data;
        end else begin
            bypass_s = rd_data;
        end
        if (load) begin
            val_d = bypass_s;
        end else begin
            val_d = val_q;
        end
    end

    // Operand register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/banco_reg_wb.sv
// banco_reg_wb: 32x32 MIPS register bank with two combinational read ports and bypassed A/B latches.
// Defining BANCO_REG_TRACE_EN adds LastWrAddr/LastWrData/WrCount write-trace outputs.
module banco_reg_wb
    import banco_reg_wb_pkg::*;
#(
    parameter int DATA_W   = banco_reg_wb_pkg::DATA_W,
    parameter int ADDR_W   = banco_reg_wb_pkg::ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int SP_RESET = SP_RESET_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic              AWrite,
    input  logic              BWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out
`ifdef BANCO_REG_TRACE_EN
    ,
    output logic [ADDR_W-1:0]      LastWrAddr,
    output logic [DATA_W-1:0]      LastWrData,
    output logic [TRACE_CNT_W-1:0] WrCount
`endif
);

    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_acc_s;

    assign wr_acc_s = wr_accepted(RegWrite, WriteReg);

    // Next-state of the register array; entry zero is pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_acc_s) begin
            regs_d[WriteReg] = WriteData;
        end else begin
            regs_d = regs_q;
        end
        regs_d[REG_ZERO] = '0;
    end

    // Register array; $sp comes out of reset pointing at the initial stack top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == REG_SP) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ReadData1 = regs_q[ReadReg1];
    assign ReadData2 = regs_q[ReadReg2];

    banco_reg_wb_operand_latch #(.WIDTH(DATA_W), .AW(ADDR_W)) u_latch_a (
        .clk     (clk),
        .reset   (reset),
        .load    (AWrite),
        .wr_en   (RegWrite),
        .wr_addr (WriteReg),
        .wr_data (WriteData),
        .rd_addr (ReadReg1),
        .rd_data (ReadData1),
        .q       (A_out)
    );

    banco_reg_wb_operand_latch #(.WIDTH(DATA_W), .AW(ADDR_W)) u_latch_b (
        .clk     (clk),
        .reset   (reset),
        .load    (BWrite),
        .wr_en   (RegWrite),
        .wr_addr (WriteReg),
        .wr_data (WriteData),
        .rd_addr (ReadReg2),
        .rd_data (ReadData2),
        .q       (B_out)
    );

`ifdef BANCO_REG_TRACE_EN
    logic [ADDR_W-1:0]      last_addr_d, last_addr_q;
    logic [DATA_W-1:0]      last_data_d, last_data_q;
    logic [TRACE_CNT_W-1:0] wr_cnt_d,    wr_cnt_q;

    // Trace next-state: record each accepted write; the counter wraps naturally.
    always_comb begin
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        wr_cnt_d    = wr_cnt_q;
        if (wr_acc_s) begin
            last_addr_d = WriteReg;
            last_data_d = WriteData;
            wr_cnt_d    = wr_cnt_q + TRACE_CNT_W'(1);
        end else begin
            wr_cnt_d    = wr_cnt_q;
        end
    end

    // Trace registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_addr_q <= '0;
            last_data_q <= '0;
            wr_cnt_q    <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign LastWrAddr = last_addr_q;
    assign LastWrData = last_data_q;
    assign WrCount    = wr_cnt_q;
`endif

endmodule

// File: tb/tb_banco_reg_wb.sv
// Scoreboard bench for banco_reg_wb: stimulus pushes model predictions, a monitor pops and compares after each edge.
module tb_banco_reg_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1, read_reg2;
    logic        a_write, b_write;
    logic [31:0] read_data1, read_data2, a_out, b_out;
`ifdef BANCO_REG_TRACE_EN
    logic [4:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    logic [15:0] wr_count;
`endif

    banco_reg_wb dut (
        .clk       (clk),
        .reset     (reset_n),
        .RegWrite  (reg_write),
        .WriteReg  (write_reg),
        .WriteData (write_data),
        .ReadReg1  (read_reg1),
        .ReadReg2  (read_reg2),
        .AWrite    (a_write),
        .BWrite    (b_write),
        .ReadData1 (read_data1),
        .ReadData2 (read_data2),
        .A_out     (a_out),
        .B_out     (b_out)
`ifdef BANCO_REG_TRACE_EN
        ,
        .LastWrAddr(last_wr_addr),
        .LastWrData(last_wr_data),
        .WrCount   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] la;
        logic [31:0] ld;
        logic [31:0] wc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model: architectural register contents and latched operands.
    logic [31:0] model [32];
    logic [31:0] m_a, m_b, m_la, m_ld, m_wc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
        m_a = 32'd0; m_b = 32'd0; m_la = 32'd0; m_ld = 32'd0; m_wc = 32'd0;
    endtask

    // One clock of stimulus; the model applies the write first, then A/B see the updated bank.
    task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input bit aw, input bit bw);
        exp_t e;
        @(negedge clk);
        reg_write = we; write_reg = wa; write_data = wd;
        read_reg1 = r1; read_reg2 = r2; a_write = aw; b_write = bw;
        if (we && wa != 5'd0) begin
            model[wa] = wd;
            m_la = {27'd0, wa};
            m_ld = wd;
            m_wc = (m_wc + 32'd1) & 32'h0000_FFFF;
        end
        if (aw) m_a = model[r1];
        if (bw) m_b = model[r2];
        e.rd1 = model[r1]; e.rd2 = model[r2]; e.a = m_a; e.b = m_b;
        e.la = m_la; e.ld = m_ld; e.wc = m_wc;
        sb.push_back(e);
    endtask

    // Monitor: one prediction is due after every edge that follows a stimulus step.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd1", read_data1, e.rd1);
            chk("rd2", read_data2, e.rd2);
            chk("a_out", a_out, e.a);
            chk("b_out", b_out, e.b);
`ifdef BANCO_REG_TRACE_EN
            chk("last_addr", {27'd0, last_wr_addr}, e.la);
            chk("last_data", last_wr_data, e.ld);
            chk("wr_count", {16'd0, wr_count}, e.wc);
`endif
        end
    end

    initial begin
        logic [4:0] wa, r1, r2;
        reset_n = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'd0;
        read_reg1 = 5'd0; read_reg2 = 5'd29; a_write = 1'b0; b_write = 1'b0;
        model_reset();
        #12;
        chk("rst_a", a_out, 32'd0);
        chk("rst_b", b_out, 32'd0);
        chk("rst_sp", read_data2, 32'd227);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset contents sweep.
        for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 1'b0);

        // Directed cases.
        step(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b0, 1'b0);
        step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, 1'b0);
        step(1'b1, 5'd31, 32'h400, 5'd0, 5'd31, 1'b0, 1'b1);
        step(1'b1, 5'd7, 32'hCAFE0001, 5'd7, 5'd7, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle.
        step(1'b1, 5'd5, 32'd7, 5'd5, 5'd5, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rd5", read_data1, 32'd0);
        chk("async_a", a_out, 32'd0);
        model_reset();
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd6; write_data = 32'h66; a_write = 1'b1; read_reg1 = 5'd6;
        repeat (2) @(negedge clk);
        reg_write = 1'b0; a_write = 1'b0;
        reset_n = 1'b1;
        step(1'b0, 5'd0, 32'd0, 5'd6, 5'd29, 1'b0, 1'b0);

        // Trace sequence (also exercises normal writes in the default build).
        step(1'b1, 5'd3, 32'd1, 5'd3, 5'd4, 1'b0, 1'b0);
        step(1'b1, 5'd0, 32'd9, 5'd0, 5'd3, 1'b0, 1'b0);
        step(1'b1, 5'd4, 32'd2, 5'd4, 5'd3, 1'b1, 1'b1);

        // Random traffic biased toward a few indices so bypass collisions are frequent.
        for (int n = 0; n < 400; n++) begin
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            r2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), wa, $urandom, r1, r2,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
